// File: rtl/dc_useq_if.sv
// dc_useq_if: request/ROM-address bundle between the decoder/PLA, the MicROM and dc_useq.
interface dc_useq_if;
   logic       cen;
   logic [8:0] ma;
   logic       ax;
   logic       pla_req;
   logic [8:0] pla_addr;
   logic       trap_req;
   logic [8:0] trap_vec;
   logic       call;
   logic [8:0] call_addr;
   logic       ret;
   logic       stall;
   logic [8:0] bkpt_addr;
   logic [9:0] a_out;
   logic       rom_cen;
   logic       mc_valid;
   logic       sp_err;
   logic       bkpt_hit;

   modport slave (
      input  cen, ma, ax, pla_req, pla_addr, trap_req, trap_vec,
             call, call_addr, ret, stall, bkpt_addr,
      output a_out, rom_cen, mc_valid, sp_err, bkpt_hit
   );

   modport master (
      output cen, ma, ax, pla_req, pla_addr, trap_req, trap_vec,
             call, call_addr, ret, stall, bkpt_addr,
      input  a_out, rom_cen, mc_valid, sp_err, bkpt_hit
   );
endinterface

// File: rtl/dc_useq.sv
// dc_useq: DC303 MicROM microsequencer - next-address select, ROM enable and return stack.
// Optional breakpoint halt is compiled in with `define DC_USEQ_BKPT_EN.
module dc_useq #(
   parameter logic [8:0] RST_VEC     = 9'h080,
   parameter int         STACK_DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   dc_useq_if.slave bus
);
   localparam int             SPW     = $clog2(STACK_DEPTH + 1);
   localparam int             IW      = $clog2(STACK_DEPTH);
   localparam logic [SPW-1:0] SP_ONE  = {{(SPW-1){1'b0}}, 1'b1};
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

`ifdef DC_USEQ_BKPT_EN
   typedef enum logic [1:0] {ST_RST = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2, ST_HALT = 2'd3} state_t;
`else
   typedef enum logic [1:0] {ST_RST = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2} state_t;
`endif

   state_t         state_r, state_nx_s;
   logic [8:0]     stack_r [STACK_DEPTH];
   logic [SPW-1:0] sp_r;
   logic [9:0]     held_r;
   logic           mc_valid_r, sp_err_r;
   logic [8:0]     sel_s;
   logic           push_s, pop_s, flush_s, err_s;
   logic           issue_s, rom_cen_s;
   logic [9:0]     a_out_s;
   logic [IW-1:0]  top_idx_s, push_idx_s;

   assign top_idx_s  = IW'(sp_r - SP_ONE);
   assign push_idx_s = IW'(sp_r);

`ifdef DC_USEQ_BKPT_EN
   logic bkpt_r;
   logic bkpt_match_s;
   assign bkpt_match_s = (sel_s == bus.bkpt_addr);
`endif

   // Next-address priority: trap, ret, pla, call, sequential ma.
   always_comb begin
      sel_s   = bus.ma;
      push_s  = 1'b0;
      pop_s   = 1'b0;
      flush_s = 1'b0;
      err_s   = 1'b0;
      if (bus.trap_req) begin
         sel_s   = bus.trap_vec;
         flush_s = 1'b1;
      end else if (bus.ret) begin
         if (sp_r == {SPW{1'b0}}) begin
            sel_s = bus.ma;
            err_s = 1'b1;
         end else begin
            sel_s = stack_r[top_idx_s];
            pop_s = 1'b1;
         end
      end else if (bus.pla_req) begin
         sel_s = bus.pla_addr;
      end else if (bus.call) begin
         sel_s = bus.call_addr;
         if (sp_r == SP_FULL) begin
            err_s = 1'b1;
         end else begin
            push_s = 1'b1;
         end
      end else begin
         sel_s = bus.ma;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_RST;
      end else if (bus.cen) begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; RUN and HOLD differ only in name, both issue as soon as stall drops.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_RST: state_nx_s = ST_RUN;
         ST_RUN,
         ST_HOLD: begin
            if (bus.stall) begin
               state_nx_s = ST_HOLD;
`ifdef DC_USEQ_BKPT_EN
            end else if (bkpt_match_s) begin
               state_nx_s = ST_HALT;
`endif
            end else begin
               state_nx_s = ST_RUN;
            end
         end
`ifdef DC_USEQ_BKPT_EN
         ST_HALT: state_nx_s = ST_HALT;
`endif
         default: state_nx_s = ST_RST;
      endcase
   end

   // Output logic: the selected address goes straight to the ROM; otherwise the last issued one is shown.
   always_comb begin
      issue_s   = 1'b0;
      rom_cen_s = 1'b0;
      a_out_s   = held_r;
      if (reset) begin
         a_out_s = {1'b0, RST_VEC};
      end else if (bus.cen) begin
         case (state_r)
            ST_RST: begin
               rom_cen_s = 1'b1;
               a_out_s   = {bus.ax, RST_VEC};
            end
            ST_RUN,
            ST_HOLD: begin
               if (!bus.stall) begin
                  issue_s   = 1'b1;
                  rom_cen_s = 1'b1;
                  a_out_s   = {bus.ax, sel_s};
               end else begin
                  a_out_s = held_r;
               end
            end
            default: a_out_s = held_r;
         endcase
      end else begin
         a_out_s = held_r;
      end
   end

   // Stack pointer, held address, valid pipeline and sticky stack error.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp_r       <= {SPW{1'b0}};
         held_r     <= {1'b0, RST_VEC};
         mc_valid_r <= 1'b0;
         sp_err_r   <= 1'b0;
      end else if (bus.cen) begin
         mc_valid_r <= rom_cen_s;
         if (rom_cen_s) begin
            held_r <= a_out_s;
         end
         if (issue_s) begin
            if (flush_s) begin
               sp_r <= {SPW{1'b0}};
            end else if (pop_s) begin
               sp_r <= sp_r - SP_ONE;
            end else if (push_s) begin
               sp_r <= sp_r + SP_ONE;
            end
            if (err_s) begin
               sp_err_r <= 1'b1;
            end
         end
      end
   end

   // Return stack storage; contents are meaningless above sp so no reset is needed.
   always_ff @(posedge clk) begin
      if (!reset && bus.cen && issue_s && push_s) begin
         stack_r[push_idx_s] <= bus.ma;
      end
   end

`ifdef DC_USEQ_BKPT_EN
   // Breakpoint flag; set together with the issue of the matching address.
   always_ff @(posedge clk) begin
      if (reset) begin
         bkpt_r <= 1'b0;
      end else if (bus.cen && issue_s && bkpt_match_s) begin
         bkpt_r <= 1'b1;
      end
   end
   assign bus.bkpt_hit = bkpt_r;
`else
   assign bus.bkpt_hit = 1'b0;
`endif

   assign bus.a_out    = a_out_s;
   assign bus.rom_cen  = rom_cen_s;
   assign bus.mc_valid = mc_valid_r;
   assign bus.sp_err   = sp_err_r;
endmodule
